// File: rtl/mem_pkg.sv
// Shared widths and FSM encoding for the burst reader and its stream buffer.
package mem_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 256;
    localparam int LEN_W     = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on rdata while not empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests; a push into a full FIFO is only taken alongside a pop.
    always_comb begin
        empty     = (count_r == {CNT_W{1'b0}});
        full      = (count_r == CNT_W'(DEPTH));
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        count     = count_r;
        if (empty) begin
            rdata = {WIDTH{1'b0}};
        end else begin
            rdata = mem_r[rd_ptr_r];
        end
    end

    // Storage array, written on accepted pushes.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mem_burst_reader.sv
// Reads a burst of consecutive memory words and streams them out through a credit-limited buffer.
module mem_burst_reader #(
    parameter int DATA_W     = mem_pkg::DATA_W,
    parameter int ADDR_W     = mem_pkg::ADDR_W,
    parameter int MEM_DEPTH  = mem_pkg::MEM_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [8:0]        len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    import mem_pkg::*;

    localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t             state_r;
    state_t             state_nx_s;
    logic               busy_r;
    logic               done_r;
    logic               err_r;
    logic               rd_req_r;
    logic               push_r;
    logic [ADDR_W-1:0]  rd_addr_r;
    logic [LEN_W-1:0]   issue_left_r;
    logic [LEN_W-1:0]   out_left_r;

    logic [ADDR_W:0]    len_ext_s;
    logic [ADDR_W:0]    end_s;
    logic               legal_s;
    logic [CNT_W-1:0]   cnt_s;
    logic [CNT_W-1:0]   cnt_nx_s;
    logic [CNT_W:0]     occ_s;
    logic               space_s;
    logic               fifo_empty_s;
    logic               fifo_full_s;
    logic [DATA_W-1:0]  fifo_rdata_s;
    logic               pop_s;
    logic               out_last_s;
    logic               accept_s;
    logic               reject_s;
    logic               issue_more_s;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_r),
        .pop   (pop_s),
        .wdata (mem_data_in),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (cnt_s)
    );

    // Request legality and the occupancy the buffer will have next cycle, plus the read in flight.
    always_comb begin
        len_ext_s  = {{(ADDR_W + 1 - LEN_W){1'b0}}, len};
        end_s      = {1'b0, base_addr} + len_ext_s;
        legal_s    = (len != {LEN_W{1'b0}}) && (len_ext_s <= DEPTH_LIM) && (end_s <= DEPTH_LIM);
        pop_s      = !fifo_empty_s && out_ready;
        out_last_s = !fifo_empty_s && (out_left_r == LEN_W'(1));
        cnt_nx_s   = cnt_s + CNT_W'(push_r) - CNT_W'(pop_s);
        occ_s      = {1'b0, cnt_nx_s} + (CNT_W + 1)'(rd_req_r);
        space_s    = (occ_s < (CNT_W + 1)'(FIFO_DEPTH)) && !(fifo_full_s && !pop_s);
    end

    // State register with registered status flags derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != IDLE);
            done_r  <= (state_nx_s == FIN);
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (start && legal_s) begin
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                if (issue_left_r == {LEN_W{1'b0}}) begin
                    state_nx_s = DRAIN;
                end else begin
                    state_nx_s = ISSUE;
                end
            end
            DRAIN: begin
                if (pop_s && out_last_s) begin
                    state_nx_s = FIN;
                end else begin
                    state_nx_s = DRAIN;
                end
            end
            FIN:     state_nx_s = IDLE;
            default: state_nx_s = IDLE;
        endcase
    end

    // Per-state control decodes.
    always_comb begin
        accept_s     = 1'b0;
        reject_s     = 1'b0;
        issue_more_s = 1'b0;
        case (state_r)
            IDLE: begin
                accept_s = start && legal_s;
                reject_s = start && !legal_s;
            end
            ISSUE:   issue_more_s = (issue_left_r != {LEN_W{1'b0}}) && space_s;
            default: issue_more_s = 1'b0;
        endcase
    end

    // Read issue, address stepping, return-data tracking and word accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_req_r     <= 1'b0;
            push_r       <= 1'b0;
            err_r        <= 1'b0;
            rd_addr_r    <= {ADDR_W{1'b0}};
            issue_left_r <= {LEN_W{1'b0}};
            out_left_r   <= {LEN_W{1'b0}};
        end else begin
            push_r <= rd_req_r;
            err_r  <= reject_s;
            if (accept_s) begin
                rd_req_r     <= 1'b1;
                rd_addr_r    <= base_addr;
                issue_left_r <= len - LEN_W'(1);
            end else if (issue_more_s) begin
                rd_req_r     <= 1'b1;
                rd_addr_r    <= rd_addr_r + ADDR_W'(1);
                issue_left_r <= issue_left_r - LEN_W'(1);
            end else begin
                rd_req_r     <= 1'b0;
            end
            if (accept_s) begin
                out_left_r <= len;
            end else if (pop_s && (out_left_r != {LEN_W{1'b0}})) begin
                out_left_r <= out_left_r - LEN_W'(1);
            end else begin
                out_left_r <= out_left_r;
            end
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign err         = err_r;
    assign mem_rd_req  = rd_req_r;
    assign mem_rd_addr = rd_addr_r;
    assign out_valid   = !fifo_empty_s;
    assign out_data    = fifo_rdata_s;
    assign out_last    = out_last_s;

endmodule

// File: tb/tb_mem_burst_reader.sv
// Randomized scoreboard bench for mem_burst_reader with a simple one-cycle-latency memory model.
module tb_mem_burst_reader;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MD = 256;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [8:0]    len;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_rd_req;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_data_in;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    mem_burst_reader #(
        .DATA_W (DW), .ADDR_W (AW), .MEM_DEPTH (MD), .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .base_addr (base_addr), .len (len),
        .busy (busy), .done (done), .err (err), .mem_rd_req (mem_rd_req),
        .mem_rd_addr (mem_rd_addr), .mem_data_in (mem_data_in), .out_valid (out_valid),
        .out_ready (out_ready), .out_data (out_data), .out_last (out_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    logic [DW-1:0] mem [MD];
    exp_t          exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            done_cnt = 0;
    int            err_cnt = 0;
    int            rdreq_cnt = 0;
    int            pop_cnt = 0;
    bit            rand_ready = 1'b0;
    bit            fixed_ready = 1'b1;

    // Memory: data is valid exactly one cycle after a read strobe, junk otherwise.
    always @(posedge clk) begin
        if (mem_rd_req) mem_data_in <= mem[mem_rd_addr[$clog2(MD)-1:0]];
        else            mem_data_in <= $urandom;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sink ready: either a fixed level or a random pattern, changed just after each edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            else            out_ready = fixed_ready;
        end
    end

    // Monitor: pops the scoreboard on each handshake and checks stall stability.
    initial begin
        bit            stall_v;
        logic [DW-1:0] stall_data;
        logic          stall_last;
        exp_t          e;
        stall_v = 1'b0;
        stall_data = '0;
        stall_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_v = 1'b0;
            end else begin
                if (done)       done_cnt++;
                if (err)        err_cnt++;
                if (mem_rd_req) rdreq_cnt++;
                if (stall_v) begin
                    check("stall_valid", 64'(out_valid), 64'd1);
                    check("stall_data", 64'(out_data), 64'(stall_data));
                    check("stall_last", 64'(out_last), 64'(stall_last));
                end
                if (out_valid && out_ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        check("spurious_word_queue", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check("word_data", 64'(out_data), 64'(e.data));
                        check("word_last", 64'(out_last), 64'(e.last));
                    end
                end
                stall_v    = out_valid && !out_ready;
                stall_data = out_data;
                stall_last = out_last;
            end
        end
    end

    task automatic push_exp(input int b, input int l);
        exp_t e;
        for (int i = 0; i < l; i++) begin
            e.data = mem[b + i];
            e.last = (i == l - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_timeout"}, 64'(k < 3000), 64'd1);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_busy"}, 64'(busy), 64'd0);
        check({nm, "_done"}, 64'(done), 64'd0);
        check({nm, "_err"}, 64'(err), 64'd0);
        check({nm, "_rd_req"}, 64'(mem_rd_req), 64'd0);
        check({nm, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
        check({nm, "_out_valid"}, 64'(out_valid), 64'd0);
        check({nm, "_out_data"}, 64'(out_data), 64'd0);
        check({nm, "_out_last"}, 64'(out_last), 64'd0);
    endtask

    task automatic run_burst(input string nm, input int b, input int l, input bit ok, input bit consec);
        int d0, r0, e0, k;
        d0 = done_cnt;
        r0 = rdreq_cnt;
        e0 = err_cnt;
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = AW'(b);
        len = 9'(l);
        if (ok) push_exp(b, l);
        @(posedge clk); #1;
        start = 1'b0;
        if (ok) begin
            check({nm, "_first_req"}, 64'(mem_rd_req), 64'd1);
            check({nm, "_first_addr"}, 64'(mem_rd_addr), 64'(b));
            check({nm, "_early_valid"}, 64'(out_valid), 64'd0);
            if (consec) begin
                k = 0;
                while (!out_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                for (int i = 0; i < l; i++) begin
                    check({nm, "_stream_valid"}, 64'(out_valid), 64'd1);
                    check({nm, "_stream_last"}, 64'(out_last), 64'(i == l - 1));
                    @(negedge clk);
                end
            end
            wait_idle(nm);
            check({nm, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
            check({nm, "_reads"}, 64'(rdreq_cnt - r0), 64'(l));
            check({nm, "_no_err"}, 64'(err_cnt - e0), 64'd0);
        end else begin
            check({nm, "_err_pulse"}, 64'(err), 64'd1);
            check({nm, "_busy"}, 64'(busy), 64'd0);
            check({nm, "_rd_req"}, 64'(mem_rd_req), 64'd0);
            @(posedge clk); #1;
            check({nm, "_err_end"}, 64'(err), 64'd0);
            check({nm, "_busy_after"}, 64'(busy), 64'd0);
            repeat (4) @(negedge clk);
            check({nm, "_no_reads"}, 64'(rdreq_cnt - r0), 64'd0);
            check({nm, "_no_done"}, 64'(done_cnt - d0), 64'd0);
            check({nm, "_err_count"}, 64'(err_cnt - e0), 64'd1);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    initial begin
        int d0, r0, p0, k, b, l;
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        len = '0;
        for (int i = 0; i < MD; i++) mem[i] = $urandom;
        mem[8'h54] = 32'hAAAA5678;
        mem[8'h55] = 32'hBBBB5678;
        mem[8'h56] = 32'hCCCC5678;
        mem[8'h57] = 32'hDDDD5678;
        repeat (3) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Single word and streaming bursts with an always-ready sink.
        run_burst("single", 32'h54, 1, 1'b1, 1'b1);
        run_burst("stream", 32'h54, 4, 1'b1, 1'b1);

        // Backpressure: the reader may only fill the buffer, then must stop issuing.
        fixed_ready = 1'b0;
        repeat (2) @(posedge clk);
        d0 = done_cnt;
        r0 = rdreq_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(32'h40); len = 9'd8;
        push_exp(32'h40, 8);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("bp_reads_capped", 64'(rdreq_cnt - r0), 64'(FD));
        check("bp_valid_held", 64'(out_valid), 64'd1);
        fixed_ready = 1'b1;
        wait_idle("bp");
        check("bp_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("bp_reads_total", 64'(rdreq_cnt - r0), 64'd8);

        // Illegal and boundary requests.
        run_burst("ill_overrun", 32'hFE, 3, 1'b0, 1'b0);
        run_burst("ill_len0", 32'h10, 0, 1'b0, 1'b0);
        run_burst("ill_len257", 32'h0, 257, 1'b0, 1'b0);
        run_burst("edge_top", 32'hFF, 1, 1'b1, 1'b0);
        rand_ready = 1'b1;
        run_burst("edge_full", 32'h0, 256, 1'b1, 1'b0);
        rand_ready = 1'b0;

        // Start while busy must be ignored.
        d0 = done_cnt;
        r0 = rdreq_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(32'h30); len = 9'd4;
        push_exp(32'h30, 4);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(32'h80); len = 9'd2;
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle("busy_start");
        repeat (6) @(negedge clk);
        check("busy_start_done", 64'(done_cnt - d0), 64'd1);
        check("busy_start_reads", 64'(rdreq_cnt - r0), 64'd4);

        // Reset in the middle of a burst, after two words have been taken.
        p0 = pop_cnt;
        @(posedge clk); #1;
        start = 1'b1; base_addr = AW'(32'h20); len = 9'd8;
        push_exp(32'h20, 8);
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while ((pop_cnt - p0) < 2 && k < 100) begin
            @(negedge clk); #1;
            k++;
        end
        check("midrst_wait", 64'(k < 100), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_zero("midrst");
        exp_q.delete();
        @(posedge clk); #1;
        check_zero("midrst_hold");
        rst = 1'b0;
        run_burst("after_rst", 32'h10, 2, 1'b1, 1'b1);

        // Randomized legal bursts against a random sink.
        rand_ready = 1'b1;
        for (int n = 0; n < 15; n++) begin
            l = $urandom_range(1, 64);
            b = $urandom_range(0, MD - l);
            run_burst("rand", b, l, 1'b1, 1'b0);
        end
        rand_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_burst_reader.md
MEM_BURST_READER -- requirements
Module: mem_burst_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the memory and stream data width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning the memory address width.
REQ-003 SHALL have parameter MEM_DEPTH, default 256, meaning the number of words in the memory.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4 (power of 2, at least 2), meaning the number of output buffer entries.
REQ-005 SHALL provide clocking and reset as decided: one clock; reset is asynchronous and active-high.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: asynchronous active-high reset.
REQ-008 SHALL provide port start, input, 1 bit: burst request, sampled in IDLE only.
REQ-009 SHALL provide port base_addr, input, ADDR_W bits: first word address of the burst.
REQ-010 SHALL provide port len, input, 9 bits: burst length in words, legal range 1..MEM_DEPTH.
REQ-011 SHALL provide port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL provide port done, output, 1 bit: one-cycle pulse at the end of a burst.
REQ-013 SHALL provide port err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-014 SHALL provide port mem_rd_req, output, 1 bit: read strobe to the memory unit.
REQ-015 SHALL provide port mem_rd_addr, output, ADDR_W bits: read address to the memory unit.
REQ-016 SHALL provide port mem_data_in, input, DATA_W bits: memory read data, valid exactly one cycle after mem_rd_req.
REQ-017 SHALL provide port out_valid, output, 1 bit: stream data valid.
REQ-018 SHALL provide port out_ready, input, 1 bit: stream sink ready.
REQ-019 SHALL provide port out_data, output, DATA_W bits: stream data word.
REQ-020 SHALL provide port out_last, output, 1 bit: marks the final word of the burst, qualified by out_valid.

Function
REQ-021 SHALL implement the FSM states IDLE, ISSUE, DRAIN and FIN.
- IDLE to ISSUE: start is high with a legal request.
- ISSUE to DRAIN: the read for the last word has been issued.
- DRAIN to FIN: the handshake of the out_last word completes.
- FIN to IDLE: unconditionally, after one cycle.
REQ-022 SHALL accept a request when len is in 1..MEM_DEPTH and base_addr+len is at most MEM_DEPTH, computed with ADDR_W+1 bits; otherwise it SHALL pulse err in the next cycle and remain in IDLE.
REQ-023 SHALL ignore start in every state other than IDLE.
REQ-024 SHALL, when start is sampled at edge N, drive mem_rd_req=1 and mem_rd_addr=base_addr in the cycle after edge N, with out_valid=1 no earlier than the cycle after edge N+1.
REQ-025 SHALL issue a read only while fifo_count + inflight < FIFO_DEPTH, where inflight is 1 if mem_rd_req was high in the previous cycle.
REQ-026 SHALL write mem_data_in into the FIFO at the edge one cycle after each issued read, with no data ever dropped.
REQ-027 SHALL increment mem_rd_addr by 1 per issued read, and SHALL hold mem_rd_addr at its last value when mem_rd_req is low.
REQ-028 SHALL sustain one word per cycle with out_ready held high.
REQ-029 SHALL transfer a word only when out_valid and out_ready are both high, and SHALL hold out_data and out_last stable while out_valid is high and out_ready is low.
REQ-030 SHALL use a show-ahead FIFO, so the head entry drives out_data; out_valid SHALL equal FIFO not-empty.
REQ-031 SHALL, when a FIFO push and pop occur in the same cycle, leave the count unchanged; this SHALL be legal when the FIFO is full.
REQ-032 SHALL assert done in FIN only.

Reset
REQ-033 SHALL, on rst high and at any time including mid-burst, immediately force the state to IDLE, flush the FIFO, and clear inflight.
REQ-034 SHALL hold the following outputs at 0 during reset: busy, done, err, mem_rd_req, mem_rd_addr, out_valid, out_data and out_last.
REQ-035 SHALL discard any mem_data_in returning after reset deassertion.

Structure
REQ-036 SHALL take DATA_W, ADDR_W, MEM_DEPTH and the FSM state enum from the shared package mem_pkg.
REQ-037 SHALL instantiate one sub-module, sync_fifo, with push, pop, full, empty, count and show-ahead read behaviour.

Verification
REQ-038 SHALL pass single-word burst: base=0x54, len=1, memory preloaded with 0xAAAA5678 -> one out word 0xAAAA5678 with out_last=1, then done pulses once.
REQ-039 SHALL pass streaming burst: base=0x54, len=4 with 0xAAAA5678, 0xBBBB5678, 0xCCCC5678, 0xDDDD5678 preloaded and out_ready=1 -> four words on consecutive cycles, out_last only on 0xDDDD5678.
REQ-040 SHALL pass backpressure: len=8 with out_ready=0 for 10 cycles -> exactly FIFO_DEPTH reads issued, no more, then all 8 words delivered in order with none lost or duplicated.
REQ-041 SHALL pass illegal request: base=0xFE, len=3 -> err pulses for 1 cycle, no mem_rd_req, busy stays 0; len=0 -> same response.
REQ-042 SHALL pass start while busy: a second start during a len=4 burst is ignored -> exactly 4 words delivered and a single done pulse.
REQ-043 SHALL pass mid-burst reset: rst asserted after 2 words of len=8 -> all outputs are 0 in the same cycle; a new burst base=0x10, len=2 then completes correctly.
